crc32: RTL and testbench

//  Byte-serial CRC-32 (IEEE 802.3 / gzip / zlib) accumulator for the GZIP trailer path.
//  - Consumes one data byte per clock when valid.
//  - Continuously presents the finalized (bit-inverted) CRC of all bytes accepted since the last reset/clear.

---
 rtl/crc32_pkg.sv | 16 +
 rtl/crc32_byte_step.sv | 21 ++
 rtl/crc32.sv | 47 ++++
 tb/tb_crc32.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/crc32_pkg.sv
// Shared constants and types for the byte-serial CRC-32 (IEEE 802.3 / gzip / zlib).
// Reflected algorithm: poly 0xEDB88320, init 0xFFFFFFFF, xorout 0xFFFFFFFF.
package crc32_pkg;

  typedef logic [31:0] crc32_t;

  localparam crc32_t CRC32_POLY   = 32'hEDB88320;
  localparam crc32_t CRC32_INIT   = 32'hFFFFFFFF;
  localparam crc32_t CRC32_XOROUT = 32'hFFFFFFFF;

  // Applies the output XOR to a raw register value.
  function automatic crc32_t crc32_finalize(input crc32_t raw);
    return raw ^ CRC32_XOROUT;
  endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// Pure combinational single-byte CRC-32 update (reflected, LSB first).
// The 8-bit inner loop unrolls into one XOR network, so a full byte is absorbed per cycle.
module crc32_byte_step
  import crc32_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  // Fold the byte into the low bits, then shift out 8 bits, applying the polynomial on each 1.
  always_comb begin
    // NOTE: crc_out is assigned first on every path, so no latch can be inferred.
    crc_out = crc_in ^ {24'b0, data_in};
    for (int i = 0; i < 8; i++) begin
      // NOTE: blocking assignments here chain each iteration into the next within the same evaluation.
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/crc32.sv
// Byte-serial CRC-32 accumulator for the GZIP trailer path.
// crc32_out always shows the finalized CRC of every byte accepted since the last restart.
// Optional feature macro: CRC32_CLEAR_EN adds crc32_clear_in, a synchronous restart
// that ranks below rst and above crc32_valid_in.
module crc32
  import crc32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  crc32_in,
  input  logic        crc32_valid_in,
`ifdef CRC32_CLEAR_EN
  input  logic        crc32_clear_in,
`endif
  output logic [31:0] crc32_out
);

  crc32_t crc_q;
  crc32_t crc_next;

  crc32_byte_step u_byte_step (
    .crc_in  (crc_q),
    .data_in (crc32_in),
    .crc_out (crc_next)
  );

  // CRC register: rst, then optional clear, then a valid byte; otherwise hold.
  // crc32_in is only looked at under crc32_valid_in, so garbage on an idle cycle is harmless.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for state so every flop updates from pre-edge values.
    if (rst) begin
      crc_q <= CRC32_INIT;
    end
`ifdef CRC32_CLEAR_EN
    else if (crc32_clear_in) begin
      crc_q <= CRC32_INIT;
    end
`endif
    else if (crc32_valid_in) begin
      crc_q <= crc_next;
    end
  end

  // Output is the inverted register directly, so a byte shows up right after the edge that took it.
  assign crc32_out = crc32_finalize(crc_q);

endmodule

// File: tb/tb_crc32.sv
// Self-checking bench for crc32: randomized and known-answer streams are scored
// against a table-driven CRC-32 reference model; a monitor compares every cycle.
module tb_crc32;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  crc32_in;
  logic        crc32_valid_in;
  logic        crc32_clear_in;
  logic [31:0] crc32_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] crc_table [256];
  logic [31:0] model_crc;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  crc32 dut (
    .clk            (clk),
    .rst            (rst),
    .crc32_in       (crc32_in),
    .crc32_valid_in (crc32_valid_in),
`ifdef CRC32_CLEAR_EN
    .crc32_clear_in (crc32_clear_in),
`endif
    .crc32_out      (crc32_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: classic 256-entry table CRC, byte-at-a-time lookup.
  function automatic logic [31:0] model_step(input logic [31:0] c, input logic [7:0] b);
    logic [7:0] idx;
    idx = c[7:0] ^ b;
    return (c >> 8) ^ crc_table[idx];
  endfunction

  task automatic build_table();
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = n;
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_table[n] = c;
    end
  endtask

  // One stimulus cycle: drive at negedge, advance model, queue the post-edge expectation.
  task automatic drive(input logic r, input logic v, input logic clr, input logic [7:0] b);
    @(negedge clk);
    rst            = r;
    crc32_valid_in = v;
    crc32_clear_in = clr;
    crc32_in       = v ? b : 8'hxx;
    if (r) model_crc = 32'hFFFFFFFF;
`ifdef CRC32_CLEAR_EN
    else if (clr) model_crc = 32'hFFFFFFFF;
`endif
    else if (v) model_crc = model_step(model_crc, b);
    exp_q.push_back(~model_crc);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic feed_str(input string s);
    for (int i = 0; i < s.len(); i++) drive(1'b0, 1'b1, 1'b0, s[i]);
  endtask

  // Go idle, let the last byte settle, then compare against a published check value.
  task automatic check_kat(input string name, input logic [31:0] exp);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check(name, crc32_out, exp);
  endtask

  // Monitor: the output is valid every cycle, so each edge retires one queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("cycle", crc32_out, exp_q.pop_front());
    end
  end

  initial begin
    int wait_cycles;
    build_table();
    model_crc      = 32'hFFFFFFFF;
    rst            = 1'b1;
    crc32_valid_in = 1'b0;
    crc32_clear_in = 1'b0;
    crc32_in       = 8'h00;

    do_reset(10);
    check_kat("reset_value", 32'h00000000);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
    check_kat("idle_hold", 32'h00000000);

    do_reset(1);
    feed_str("0123456789");
    check_kat("ascii_0_9", 32'hA684C7C6);

    do_reset(1);
    feed_str("123456789");
    check_kat("check_123456789", 32'hCBF43926);

    do_reset(1);
    for (int i = 0; i < 32; i++) drive(1'b0, 1'b1, 1'b0, 8'h00);
    check_kat("zeros_32", 32'h190A55AD);

    do_reset(1);
    for (int i = 0; i < 32; i++) drive(1'b0, 1'b1, 1'b0, 8'hFF);
    check_kat("ones_32", 32'hFF6CAB0B);

    do_reset(1);
    for (int i = 0; i < 32; i++) drive(1'b0, 1'b1, 1'b0, 8'(i));
    check_kat("ramp_32", 32'h91267E8A);

    do_reset(1);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'(i));
      drive(1'b0, 1'b0, 1'b0, 8'h00);
    end
    check_kat("ramp_32_gaps", 32'h91267E8A);

    do_reset(1);
    feed_str("The quick brown ");
    do_reset(1);
    feed_str("The quick brown fox jumps over the lazy dog");
    check_kat("fox_after_midreset", 32'h414FA339);

`ifdef CRC32_CLEAR_EN
    do_reset(1);
    feed_str("01");
    drive(1'b0, 1'b1, 1'b1, 8'h41);
    feed_str("0123456789");
    check_kat("clear_restart", 32'hA684C7C6);
    // rst outranks clear and valid in the same cycle.
    feed_str("xyz");
    drive(1'b1, 1'b1, 1'b1, 8'h55);
    check_kat("rst_over_clear", 32'h00000000);
`endif

    // Randomized traffic with sporadic resets (and clears when built in).
    do_reset(1);
    for (int i = 0; i < 2000; i++) begin
      logic r, v, c;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
`ifdef CRC32_CLEAR_EN
      c = ($urandom_range(0, 49) == 0);
`else
      c = 1'b0;
`endif
      drive(r, v, c, 8'($urandom));
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
